// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, FSM encoding,
// trap causes, pc_sel codes and the opcode-class bundle.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL      = 2'd0;
  localparam logic [1:0] CAUSE_IMEM_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_DMEM_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ENV          = 2'd3;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  typedef struct packed {
    logic legal;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_fence;
    logic is_env;
  } op_class_t;

endpackage

// File: rtl/rv_op_class.sv
// Combinational opcode classifier feeding the sequencer FSM.
// Zero latency, no flow control.
module rv_op_class
  import rv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [11:0] imm12,
  output op_class_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: cls.legal = 1'b1;
      OPC_JAL: begin
        cls.legal  = 1'b1;
        cls.is_jal = 1'b1;
      end
      OPC_JALR: begin
        cls.legal   = 1'b1;
        cls.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        cls.legal     = 1'b1;
        cls.is_branch = 1'b1;
      end
      OPC_LOAD: begin
        cls.legal   = 1'b1;
        cls.is_load = 1'b1;
      end
      OPC_STORE: begin
        cls.legal    = 1'b1;
        cls.is_store = 1'b1;
      end
      OPC_FENCE: begin
        cls.legal    = 1'b1;
        cls.is_fence = 1'b1;
      end
      // Only ECALL (imm 0) and EBREAK (imm 1) are supported; CSR ops are illegal here.
      OPC_SYSTEM: begin
        cls.legal  = (imm12[11:1] == 11'd0);
        cls.is_env = (imm12[11:1] == 11'd0);
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I sequencer: 5 cycles ALU op, 6 load/store, 3 FENCE at minimum.
// Stalls on imem/dmem ack (trap after TIMEOUT cycles) and on alu_done (unbounded).
module rv_mc_sequencer
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ir,
  output logic            alu_go,
  input  logic            alu_done,
  input  logic            branch_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            trap,
  output logic [1:0]      trap_cause,
  input  logic            trap_ack,
  output logic [2:0]      state_o,
  output logic [XLEN-1:0] instret
);

  localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] to_cnt_q;
  logic          to_expired, to_clr;
  logic          exec_first_q;
  logic [1:0]    cause_q, cause_d;
  logic          ir_ld, retire;
  op_class_t     cls;

  rv_op_class u_op_class (
    .opcode (ir[6:0]),
    .imm12  (ir[31:20]),
    .cls    (cls)
  );

  assign to_expired = (to_cnt_q == TO_LAST);
  assign to_clr     = (state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir           <= '0;
      instret      <= '0;
      cause_q      <= CAUSE_ILLEGAL;
      to_cnt_q     <= '0;
      exec_first_q <= 1'b0;
    end else begin
      if (ir_ld) begin
        ir <= imem_rdata;
      end
      if (retire) begin
        instret <= instret + XLEN'(1);
      end
      cause_q <= cause_d;
      // Marks the first EXEC cycle: alu_go fires there and alu_done is ignored.
      exec_first_q <= (state_d == ST_EXEC) && (state_q != ST_EXEC);
      if (to_clr) begin
        to_cnt_q <= '0;
      end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !to_expired) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    ir_ld    = 1'b0;
    retire   = 1'b0;
    imem_req = 1'b0;
    alu_go   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PLUS4;
    trap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld   = 1'b1;
          state_d = ST_DECODE;
        end else if (to_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!cls.legal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (cls.is_env) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ENV;
        end else if (cls.is_fence) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_go = exec_first_q;
        if (!exec_first_q && alu_done) begin
          state_d = (cls.is_load || cls.is_store) ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.is_store;
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (to_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TIMEOUT;
        end
      end
      ST_WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        rf_we  = !(cls.is_branch || cls.is_store || cls.is_fence);
        if (cls.is_jal || (cls.is_branch && branch_taken)) begin
          pc_sel = PC_SEL_TARGET;
        end else if (cls.is_jalr) begin
          pc_sel = PC_SEL_JALR;
        end
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        trap = 1'b1;
        if (trap_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Randomized scoreboard bench for rv_mc_sequencer against an instruction-level reference model.
module tb_rv_mc_sequencer;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst, run;
  logic            imem_req, imem_ack;
  logic [XLEN-1:0] imem_rdata, ir;
  logic            alu_go, alu_done, branch_taken;
  logic            dmem_req, dmem_we, dmem_ack;
  logic            rf_we, pc_we;
  logic [1:0]      pc_sel;
  logic            trap, trap_ack;
  logic [1:0]      trap_cause;
  logic [2:0]      state_o;
  logic [XLEN-1:0] instret;

  always #5 clk = ~clk;

  rv_mc_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
    .alu_go(alu_go), .alu_done(alu_done), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .trap_ack(trap_ack),
    .state_o(state_o), .instret(instret)
  );

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_FENCE, K_ILL, K_ENV} kind_t;

  typedef struct {
    bit          is_trap;
    logic [1:0]  cause;
    logic        rf_we;
    logic [1:0]  pc_sel;
    int          lat;
    logic [31:0] instret_before;
  } exp_t;

  exp_t exp_q[$];
  bit   dwe_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   model_instret = 0;
  int   exp_alu = 0, n_go = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int w);
    case (w)
      0:       return imem_req;
      1:       return alu_go;
      2:       return dmem_req;
      default: return trap;
    endcase
  endfunction

  task automatic wait_on(input int w, input int limit, input string name);
    int n = 0;
    while (sig_of(w) !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk(name, sig_of(w), 1);
  endtask

  // Instruction-level view of RV32I opcode classes.
  function automatic kind_t classify(input logic [31:0] w);
    case (w[6:0])
      7'h37, 7'h17, 7'h13, 7'h33: return K_ALU;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h63: return K_BRANCH;
      7'h03: return K_LOAD;
      7'h23: return K_STORE;
      7'h0F: return K_FENCE;
      7'h73: return (w[31:20] == 12'd0 || w[31:20] == 12'd1) ? K_ENV : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  task automatic ack_trap();
    repeat ($urandom_range(0, 2)) step();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    chk("trap_cleared", trap, 0);
    chk("idle_after_ack", state_o, 0);
  endtask

  task automatic issue(input logic [31:0] w, input bit tk, input int id, input int ad,
                       input int dd, input bit dmem_never, input bit drop_run);
    kind_t k        = classify(w);
    bit    dec_trap = (k == K_ILL || k == K_ENV);
    bit    exec     = !dec_trap && k != K_FENCE;
    bit    mem      = (k == K_LOAD || k == K_STORE);
    exp_t  e;
    e.is_trap = dec_trap || (mem && dmem_never);
    e.cause   = (k == K_ILL) ? 2'd0 : (k == K_ENV) ? 2'd3 : 2'd2;
    e.rf_we   = !(k == K_BRANCH || k == K_STORE || k == K_FENCE);
    e.pc_sel  = (k == K_JAL || (k == K_BRANCH && tk)) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
    if (dec_trap) e.lat = id + 3;
    else e.lat = (id + 1) + 1 + (exec ? ad + 2 : 0) + (mem ? (dmem_never ? TIMEOUT : dd + 1) : 0) + 1;
    e.instret_before = model_instret;

    wait_on(0, 8, "imem_req_rise");
    repeat (id) step();
    imem_rdata   = w;
    branch_taken = tk;
    imem_ack     = 1'b1;
    exp_q.push_back(e);
    if (mem) dwe_q.push_back(k == K_STORE);
    if (exec) exp_alu++;
    if (!e.is_trap) model_instret++;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    if (dec_trap) begin
      wait_on(3, 4, "decode_trap");
      ack_trap();
    end else if (exec) begin
      wait_on(1, 4, "alu_go");
      if (drop_run) run = 1'b0;
      alu_done = 1'($urandom_range(0, 1));
      step();
      alu_done = 1'b0;
      repeat (ad) step();
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      if (mem) begin
        wait_on(2, 2, "dmem_req");
        if (dmem_never) begin
          wait_on(3, TIMEOUT + 4, "dmem_timeout_trap");
          ack_trap();
        end else begin
          repeat (dd) step();
          dmem_ack = 1'b1;
          step();
          dmem_ack = 1'b0;
        end
      end
    end
  endtask

  task automatic imem_timeout();
    exp_t e;
    e.is_trap        = 1'b1;
    e.cause          = 2'd1;
    e.rf_we          = 1'b0;
    e.pc_sel         = 2'd0;
    e.lat            = TIMEOUT + 1;
    e.instret_before = model_instret;
    wait_on(0, 8, "imem_req_rise");
    exp_q.push_back(e);
    wait_on(3, TIMEOUT + 4, "imem_timeout_trap");
    ack_trap();
  endtask

  // Monitor: pops scoreboard entries on retire, trap and data-request events.
  logic prev_req, prev_dreq, prev_trap, prev_go;
  int   cyc;
  exp_t me;
  initial begin
    prev_req = 0; prev_dreq = 0; prev_trap = 0; prev_go = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0; prev_dreq = 0; prev_trap = 0; prev_go = 0;
        continue;
      end
      if (imem_req && !prev_req) cyc = 1;
      else cyc++;
      if (alu_go) begin
        chk("alu_go_single_cycle", prev_go, 0);
        n_go++;
      end
      if (dmem_req && !prev_dreq) begin
        if (dwe_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dmem_unexpected: got dmem_req, expected none at %0t", $time);
        end else chk("dmem_we", dmem_we, dwe_q.pop_front());
      end
      if (pc_we || (trap && !prev_trap)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL event_unexpected: got pc_we=%0b trap=%0b, expected no event", pc_we, trap);
        end else begin
          me = exp_q.pop_front();
          chk("event_kind", {trap, pc_we}, me.is_trap ? 2'b10 : 2'b01);
          chk("latency", cyc, me.lat);
          chk("instret", instret, me.instret_before);
          if (me.is_trap) begin
            chk("trap_cause", trap_cause, me.cause);
            chk("trap_no_writes", {pc_we, rf_we}, 0);
          end else begin
            chk("rf_we", rf_we, me.rf_we);
            chk("pc_sel", pc_sel, me.pc_sel);
          end
        end
      end
      prev_req  = imem_req;
      prev_dreq = dmem_req;
      prev_trap = trap;
      prev_go   = alu_go;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [31:0] prog [14] = '{
    32'h00500093, 32'h002081B3, 32'h123452B7, 32'h00001317, 32'h008000EF, 32'h000080E7,
    32'h00208463, 32'h0000A103, 32'h0020A023, 32'h0FF0000F, 32'h00100073, 32'h00000073,
    32'h0000007F, 32'h30200073
  };
  logic [31:0] w;

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; alu_done = 1'b0;
    branch_taken = 1'b0; dmem_ack = 1'b0; trap_ack = 1'b0;
    #1;
    chk("reset_state", state_o, 0);
    chk("reset_ir", ir, 0);
    chk("reset_instret", instret, 0);
    chk("reset_outputs", {imem_req, alu_go, dmem_req, rf_we, pc_we, trap}, 0);
    repeat (3) step();
    rst = 1'b0;
    run = 1'b1;

    issue(32'h00500093, 0, 0, 0, 0, 0, 0);   // ADDI, minimum latency
    issue(32'h0000A103, 0, 0, 0, 3, 0, 0);   // LW
    issue(32'h0020A023, 1, 0, 0, 3, 0, 0);   // SW
    issue(32'h00208463, 1, 1, 0, 0, 0, 0);   // BEQ taken
    issue(32'h00208463, 0, 0, 2, 0, 0, 0);   // BEQ not taken
    issue(32'h000080E7, 1, 0, 0, 0, 0, 0);   // JALR
    issue(32'h008000EF, 0, 0, 1, 0, 0, 0);   // JAL
    issue(32'h0FF0000F, 1, 0, 0, 0, 0, 0);   // FENCE
    issue(32'h0000007F, 0, 0, 0, 0, 0, 0);   // illegal opcode
    issue(32'h00100073, 0, 2, 0, 0, 0, 0);   // EBREAK
    issue(32'h00000073, 0, 0, 0, 0, 0, 0);   // ECALL
    issue(32'h30200073, 0, 0, 0, 0, 0, 0);   // non-env SYSTEM
    imem_timeout();
    issue(32'h0000A103, 0, 0, 0, 0, 1, 0);   // LW with dmem never acking
    issue(32'h002081B3, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) w = $urandom();
      else w = prog[$urandom_range(0, 13)];
      issue(w, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 4), 0, 0);
    end

    issue(32'h00500093, 0, 0, 1, 0, 0, 1);   // run dropped while in EXEC
    repeat (4) step();
    chk("run_drop_idle", state_o, 0);
    chk("run_drop_no_fetch", imem_req, 0);
    chk("instret_total", instret, model_instret);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("alu_go_count", n_go, exp_alu);
    run = 1'b1;

    // Reset while a load is waiting in MEM.
    wait_on(0, 8, "imem_req_rise");
    imem_rdata = 32'h0000A103;
    imem_ack   = 1'b1;
    dwe_q.push_back(1'b0);
    step();
    imem_ack = 1'b0;
    wait_on(1, 4, "alu_go");
    alu_done = 1'b1;
    step();
    step();
    alu_done = 1'b0;
    wait_on(2, 2, "dmem_req");
    rst = 1'b1;
    #1;
    chk("rst_drops_dmem_req", dmem_req, 0);
    chk("rst_state", state_o, 0);
    chk("rst_instret", instret, 0);
    chk("rst_ir", ir, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
